// File: rtl/alu_issue_if.sv
// Command (upstream) and result (downstream) valid/ready channels of alu_issue.
// master = producer of commands / consumer of results; slave = alu_issue.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [3:0]  in_cmd;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_y;
  logic [3:0]  res_cmd;
  logic        res_err;

  modport master (
    output in_valid, in_a, in_b, in_cmd, res_ready,
    input  in_ready, res_valid, res_y, res_cmd, res_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cmd, res_ready,
    output in_ready, res_valid, res_y, res_cmd, res_err
  );
endinterface

// File: rtl/alu_issue.sv
// Command FIFO plus issue FSM that drives an external tri-state ALU and holds its result.
// Optional macro ALU_ISSUE_DIV0_TRAP_EN: DIV (0101) with b==0 yields res_y=16'hFFFF, res_err=1.
//
// state | meaning
// IDLE  | ALU idle; pop FIFO head into the ALU operand registers when not empty
// EXEC  | ALU output enabled for one cycle; result captured at the closing edge
// HOLD  | result presented on res_*; on handshake issue next command or go idle
module alu_issue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_issue_if.slave             bus,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [3:0]             alu_cmd,
  output logic                   alu_oe,
  input  logic [15:0]            alu_y,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push;
  logic          pop;
  logic          empty;
  logic          res_valid_c;
  logic [15:0]   res_y_q;
  logic [3:0]    res_cmd_q;
  logic          res_err_q;

  assign empty         = (count == '0);
  assign bus.in_ready  = (count != FULL);
  assign push          = bus.in_valid && bus.in_ready;
  assign bus.res_valid = res_valid_c;
  assign bus.res_y     = res_y_q;
  assign bus.res_cmd   = res_cmd_q;
  assign bus.res_err   = res_err_q;

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    alu_oe      = 1'b0;
    res_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_oe  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        res_valid_c = 1'b1;
        // back-to-back issue on handshake avoids an IDLE bubble
        if (bus.res_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {bus.in_cmd, bus.in_a, bus.in_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_cmd <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
    end else if (pop) begin
      {alu_cmd, alu_a, alu_b} <= mem[rptr];
    end
  end

`ifdef ALU_ISSUE_DIV0_TRAP_EN
  logic div0;
  assign div0 = (alu_cmd == 4'b0101) && (alu_b == 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_y_q   <= '0;
      res_cmd_q <= '0;
      res_err_q <= 1'b0;
    end else if (state_q == EXEC) begin
      res_y_q   <= div0 ? 16'hFFFF : alu_y;
      res_cmd_q <= alu_cmd;
      res_err_q <= div0;
    end
  end
`else
  assign res_err_q = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_y_q   <= '0;
      res_cmd_q <= '0;
    end else if (state_q == EXEC) begin
      res_y_q   <= alu_y;
      res_cmd_q <= alu_cmd;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: vector table, scoreboard and multi-cycle corner sequences.
module tb_alu_issue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_cmd;
  logic        alu_oe;
  wire  [15:0] alu_y;
  logic [2:0]  count;

  always #5 clk = ~clk;

  alu_issue_if bus ();

  alu_issue #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_cmd (alu_cmd),
    .alu_oe  (alu_oe),
    .alu_y   (alu_y),
    .count   (count)
  );

  typedef struct {
    logic [15:0] y;
    logic [3:0]  cmd;
    logic        err;
  } res_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y;
    logic        err;
  } vec_t;

  res_t sb[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // external ALU model: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 DIV, 6 XOR, 15 BUF
  function automatic logic [15:0] alu_fn(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      4'h0: return {8'h00, a} + {8'h00, b};
      4'h1: return {8'h00, a} - {8'h00, b};
      4'h2: return {8'h00, a & b};
      4'h3: return {8'h00, a | b};
      4'h4: return {8'h00, a} * {8'h00, b};
      4'h5: return (b == 8'h00) ? 16'h0000 : {8'h00, a / b};
      4'h6: return {8'h00, a ^ b};
      4'hF: return {8'h00, a};
      default: return {b, a};
    endcase
  endfunction

  assign alu_y = alu_oe ? alu_fn(alu_cmd, alu_a, alu_b) : 16'hzzzz;

  function automatic res_t expect_of(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    res_t r;
    r.y   = alu_fn(c, a, b);
    r.cmd = c;
    r.err = 1'b0;
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    if (c == 4'h5 && b == 8'h00) begin
      r.y   = 16'hFFFF;
      r.err = 1'b1;
    end
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout/empty expected event", name);
  endtask

  // Called at a falling edge with inputs already set: records handshakes that
  // the next rising edge will perform, then advances to the next falling edge.
  task automatic cyc(output bit acc);
    bit   hs_in;
    bit   hs_res;
    res_t e;
    hs_in  = !rst && bus.in_valid && bus.in_ready;
    hs_res = !rst && bus.res_valid && bus.res_ready;
    if (!rst) begin
      chk("in_ready_vs_count", {31'd0, bus.in_ready}, {31'd0, count != 3'(DEPTH)});
      if (bus.res_valid && alu_oe) fail_now("res_valid_with_alu_oe");
    end
    if (hs_res) begin
      if (sb.size() == 0) begin
        fail_now("sb_unexpected_result");
      end else begin
        e = sb.pop_front();
        chk("sb_res_y", {16'd0, bus.res_y}, {16'd0, e.y});
        chk("sb_res_cmd", {28'd0, bus.res_cmd}, {28'd0, e.cmd});
        chk("sb_res_err", {31'd0, bus.res_err}, {31'd0, e.err});
      end
    end
    if (hs_in) sb.push_back(expect_of(bus.in_cmd, bus.in_a, bus.in_b));
    acc = hs_in;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    bit d;
    cyc(d);
  endtask

  task automatic push_wait(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    bit acc;
    bus.in_valid = 1'b1;
    bus.in_cmd   = c;
    bus.in_a     = a;
    bus.in_b     = b;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) cyc(acc);
    bus.in_valid = 1'b0;
    if (!acc) fail_now("push_timeout");
  endtask

  task automatic wait_res(input int max);
    int i;
    i = 0;
    while (!bus.res_valid && i < max) begin
      step();
      i++;
    end
    if (!bus.res_valid) fail_now("wait_res_timeout");
  endtask

  task automatic drain(input int max);
    int i;
    i = 0;
    bus.res_ready = 1'b1;
    while ((sb.size() != 0 || bus.res_valid) && i < max) begin
      step();
      i++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    bit           acc;
    int           idx;
    int           n_pulse;
    int           pulse_cyc[$];
    logic [15:0]  pulse_y[$];
    logic [15:0]  mul_exp[4];
    logic [7:0]   b_expect;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cmd    = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_alu_a", {24'd0, alu_a}, 32'h0);
    chk("rst_alu_b", {24'd0, alu_b}, 32'h0);
    chk("rst_alu_cmd", {28'd0, alu_cmd}, 32'h0);
    chk("rst_alu_oe", {31'd0, alu_oe}, 32'h0);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'h0);
    chk("rst_res_y", {16'd0, bus.res_y}, 32'h0);
    chk("rst_res_cmd", {28'd0, bus.res_cmd}, 32'h0);
    chk("rst_res_err", {31'd0, bus.res_err}, 32'h0);
    chk("rst_count", {29'd0, count}, 32'h0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'h1);

    // single ADD latency
    bus.in_valid = 1'b1;
    bus.in_cmd   = 4'h0;
    bus.in_a     = 8'h0F;
    bus.in_b     = 8'h01;
    cyc(acc);
    bus.in_valid = 1'b0;
    chk("lat_accept", {31'd0, acc}, 32'h1);
    chk("lat_n_oe", {31'd0, alu_oe}, 32'h0);
    chk("lat_n_count", {29'd0, count}, 32'h1);
    step();
    chk("lat_n1_oe", {31'd0, alu_oe}, 32'h1);
    chk("lat_n1_res_valid", {31'd0, bus.res_valid}, 32'h0);
    chk("lat_n1_alu_a", {24'd0, alu_a}, 32'h0F);
    chk("lat_n1_alu_b", {24'd0, alu_b}, 32'h01);
    step();
    chk("lat_n2_res_valid", {31'd0, bus.res_valid}, 32'h1);
    chk("lat_n2_oe", {31'd0, alu_oe}, 32'h0);
    chk("lat_n2_res_y", {16'd0, bus.res_y}, 32'h0010);
    chk("lat_n2_res_cmd", {28'd0, bus.res_cmd}, 32'h0);
    step();
    chk("hold_stable_valid", {31'd0, bus.res_valid}, 32'h1);
    chk("hold_stable_res_y", {16'd0, bus.res_y}, 32'h0010);
    bus.res_ready = 1'b1;
    step();
    chk("after_hs_idle_valid", {31'd0, bus.res_valid}, 32'h0);

    // vector table
    vecs.push_back('{4'h0, 8'h0F, 8'h01, 16'h0010, 1'b0});
    vecs.push_back('{4'h0, 8'hFF, 8'hFF, 16'h01FE, 1'b0});
    vecs.push_back('{4'h1, 8'h05, 8'h03, 16'h0002, 1'b0});
    vecs.push_back('{4'h1, 8'h03, 8'h05, 16'hFFFE, 1'b0});
    vecs.push_back('{4'h2, 8'hF0, 8'h3C, 16'h0030, 1'b0});
    vecs.push_back('{4'h3, 8'hF0, 8'h0F, 16'h00FF, 1'b0});
    vecs.push_back('{4'h4, 8'h03, 8'h05, 16'h000F, 1'b0});
    vecs.push_back('{4'h4, 8'hFF, 8'hFF, 16'hFE01, 1'b0});
    vecs.push_back('{4'h5, 8'h0A, 8'h03, 16'h0003, 1'b0});
    vecs.push_back('{4'h6, 8'hAA, 8'hFF, 16'h0055, 1'b0});
    vecs.push_back('{4'hF, 8'h5A, 8'h00, 16'h005A, 1'b0});
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    vecs.push_back('{4'h5, 8'h0A, 8'h00, 16'hFFFF, 1'b1});
`else
    vecs.push_back('{4'h5, 8'h0A, 8'h00, 16'h0000, 1'b0});
`endif
    bus.res_ready = 1'b1;
    foreach (vecs[i]) begin
      push_wait(vecs[i].cmd, vecs[i].a, vecs[i].b);
      wait_res(10);
      chk($sformatf("vec%0d_res_y", i), {16'd0, bus.res_y}, {16'd0, vecs[i].y});
      chk($sformatf("vec%0d_res_cmd", i), {28'd0, bus.res_cmd}, {28'd0, vecs[i].cmd});
      chk($sformatf("vec%0d_res_err", i), {31'd0, bus.res_err}, {31'd0, vecs[i].err});
      step();
    end

    // four MULs with res_ready held high: one result every two cycles
    mul_exp[0] = 16'd15;
    mul_exp[1] = 16'd65025;
    mul_exp[2] = 16'd0;
    mul_exp[3] = 16'd256;
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      if (bus.res_valid) begin
        pulse_cyc.push_back(c);
        pulse_y.push_back(bus.res_y);
      end
      bus.in_valid = (idx < 4);
      bus.in_cmd   = 4'h4;
      case (idx)
        0: begin bus.in_a = 8'd3;   bus.in_b = 8'd5;   end
        1: begin bus.in_a = 8'd255; bus.in_b = 8'd255; end
        2: begin bus.in_a = 8'd0;   bus.in_b = 8'd7;   end
        default: begin bus.in_a = 8'd16; bus.in_b = 8'd16; end
      endcase
      cyc(acc);
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    chk("mul_pulses", pulse_cyc.size(), 32'd4);
    for (int k = 0; k < pulse_y.size() && k < 4; k++)
      chk($sformatf("mul%0d_res_y", k), {16'd0, pulse_y[k]}, {16'd0, mul_exp[k]});
    for (int k = 1; k < pulse_cyc.size(); k++)
      chk($sformatf("mul_spacing%0d", k), pulse_cyc[k] - pulse_cyc[k-1], 32'd2);

    // back-pressure: FIFO fills, in_ready drops, sixth command waits
    bus.res_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = (idx < 6);
      bus.in_cmd   = 4'h0;
      bus.in_a     = 8'(idx * 16);
      bus.in_b     = 8'(idx + 1);
      cyc(acc);
      if (acc) idx++;
    end
    chk("bp_count_full", {29'd0, count}, DEPTH);
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'h0);
    chk("bp_res_valid", {31'd0, bus.res_valid}, 32'h1);
    chk("bp_accepted", idx, DEPTH + 1);
    bus.res_ready = 1'b1;
    for (int c = 0; c < 40 && (idx < 6 || sb.size() != 0); c++) begin
      bus.in_valid = (idx < 6);
      bus.in_a     = 8'(idx * 16);
      bus.in_b     = 8'(idx + 1);
      cyc(acc);
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    chk("bp_all_accepted", idx, 32'd6);
    drain(20);

    // simultaneous push and pop at count == 2
    bus.res_ready = 1'b0;
    push_wait(4'h1, 8'h40, 8'h01);
    push_wait(4'h2, 8'h41, 8'h0F);
    push_wait(4'h3, 8'h42, 8'hF0);
    wait_res(10);
    chk("pp_pre_count", {29'd0, count}, 32'd2);
    bus.res_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_cmd    = 4'h6;
    bus.in_a      = 8'h43;
    bus.in_b      = 8'h33;
    b_expect      = 8'h41;
    cyc(acc);
    bus.in_valid = 1'b0;
    chk("pp_accept", {31'd0, acc}, 32'h1);
    chk("pp_count", {29'd0, count}, 32'd2);
    chk("pp_order_alu_a", {24'd0, alu_a}, {24'd0, b_expect});
    chk("pp_exec_oe", {31'd0, alu_oe}, 32'h1);
    drain(20);

    // reset during HOLD with two queued commands
    bus.res_ready = 1'b0;
    push_wait(4'h0, 8'h01, 8'h02);
    push_wait(4'h0, 8'h03, 8'h04);
    push_wait(4'h0, 8'h05, 8'h06);
    wait_res(10);
    chk("rh_pre_count", {29'd0, count}, 32'd2);
    rst = 1'b1;
    #1;
    chk("rh_res_valid", {31'd0, bus.res_valid}, 32'h0);
    chk("rh_count", {29'd0, count}, 32'h0);
    chk("rh_alu_oe", {31'd0, alu_oe}, 32'h0);
    chk("rh_res_y", {16'd0, bus.res_y}, 32'h0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.res_ready = 1'b1;
    n_pulse = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.res_valid || alu_oe) n_pulse++;
      step();
    end
    chk("rh_no_result", n_pulse, 32'd0);
    chk("rh_post_count", {29'd0, count}, 32'h0);
    chk("rh_post_in_ready", {31'd0, bus.in_ready}, 32'h1);
    chk("sb_leftover", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
